// File: rtl/cpu4_wbck.sv
// cpu4_wbck: register-file writeback arbiter. Merges the single-cycle ALU path
// with a FIFO-buffered long-latency path and reports pending long destinations.
`ifndef CPU4_XLEN
`define CPU4_XLEN 32
`endif
`ifndef CPU4_RFIDX_WIDTH
`define CPU4_RFIDX_WIDTH 5
`endif

module cpu4_wbck #(
   parameter int XLEN      = `CPU4_XLEN,
   parameter int RFIDX_W   = `CPU4_RFIDX_WIDTH,
   parameter int LNG_DEPTH = 2,
   parameter int MAX_STALL = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       alu_wbck_valid,
   output logic                       alu_wbck_ready,
   input  logic [RFIDX_W-1:0]         alu_wbck_idx,
   input  logic [XLEN-1:0]            alu_wbck_data,
   input  logic                       lng_wbck_valid,
   output logic                       lng_wbck_ready,
   input  logic [RFIDX_W-1:0]         lng_wbck_idx,
   input  logic [XLEN-1:0]            lng_wbck_data,
   output logic                       rd_wen,
   output logic [RFIDX_W-1:0]         rd_idx,
   output logic [XLEN-1:0]            rd_data,
   input  logic [RFIDX_W-1:0]         rs1_idx,
   input  logic [RFIDX_W-1:0]         rs2_idx,
   output logic                       pend_hit1,
   output logic                       pend_hit2,
   output logic [$clog2(LNG_DEPTH):0] lng_pend_cnt
);

   localparam int PTR_W = $clog2(LNG_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int STV_W = $clog2(MAX_STALL + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LNG_DEPTH);
   localparam logic [STV_W-1:0] STV_MAX  = STV_W'(MAX_STALL);

   typedef enum logic [1:0] {
      SEL_NONE = 2'd0,
      SEL_ALU  = 2'd1,
      SEL_LNG  = 2'd2
   } sel_e;

   logic [LNG_DEPTH-1:0][RFIDX_W-1:0] mem_idx_r;
   logic [XLEN-1:0]                   mem_data_r [LNG_DEPTH];
   logic [LNG_DEPTH-1:0]              vld_r;
   logic [PTR_W-1:0]                  wptr_r;
   logic [PTR_W-1:0]                  rptr_r;
   logic [CNT_W-1:0]                  cnt_r;
   logic [CNT_W-1:0]                  cnt_nxt_s;
   logic [STV_W-1:0]                  starve_r;
   logic [STV_W-1:0]                  starve_nxt_s;
   sel_e                              sel_s;
   logic                              push_s;
   logic                              pop_s;
   logic                              fifo_empty_s;
   logic                              fifo_full_s;

   // True when a nonzero operand index matches any valid FIFO entry.
   function automatic logic pend_match(
      input logic [RFIDX_W-1:0]              rs,
      input logic [LNG_DEPTH-1:0]            vld,
      input logic [LNG_DEPTH-1:0][RFIDX_W-1:0] idxs
   );
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < LNG_DEPTH; i++) begin
         hit = hit | (vld[i] & (idxs[i] == rs));
      end
      return hit & (rs != {RFIDX_W{1'b0}});
   endfunction

   assign fifo_empty_s = (cnt_r == {CNT_W{1'b0}});
   assign fifo_full_s  = (cnt_r == CNT_FULL);
   assign lng_pend_cnt = cnt_r;

   // FIFO acceptance and pending-hit reporting, all gated off during reset.
   always_comb begin
      lng_wbck_ready = 1'b0;
      pend_hit1      = 1'b0;
      pend_hit2      = 1'b0;
      if (rst) begin
         lng_wbck_ready = 1'b0;
         pend_hit1      = 1'b0;
         pend_hit2      = 1'b0;
      end else begin
         lng_wbck_ready = ~fifo_full_s;
         pend_hit1      = pend_match(rs1_idx, vld_r, mem_idx_r);
         pend_hit2      = pend_match(rs2_idx, vld_r, mem_idx_r);
      end
      push_s = lng_wbck_valid & lng_wbck_ready;
   end

   // Per-cycle source selection with the starvation bound on the long path.
   always_comb begin
      alu_wbck_ready = 1'b0;
      pop_s          = 1'b0;
      sel_s          = SEL_NONE;
      starve_nxt_s   = {STV_W{1'b0}};
      if (rst) begin
         alu_wbck_ready = 1'b0;
         sel_s          = SEL_NONE;
      end else if (fifo_empty_s) begin
         alu_wbck_ready = 1'b1;
         if (alu_wbck_valid) begin
            sel_s = SEL_ALU;
         end else begin
            sel_s = SEL_NONE;
         end
      end else if (starve_r < STV_MAX) begin
         alu_wbck_ready = 1'b1;
         if (alu_wbck_valid) begin
            sel_s        = SEL_ALU;
            starve_nxt_s = starve_r + STV_W'(1);
         end else begin
            sel_s = SEL_LNG;
            pop_s = 1'b1;
         end
      end else begin
         alu_wbck_ready = 1'b0;
         sel_s          = SEL_LNG;
         pop_s          = 1'b1;
      end
   end

   // Write-port mux; x0 destinations are consumed without a write enable.
   always_comb begin
      rd_idx  = {RFIDX_W{1'b0}};
      rd_data = {XLEN{1'b0}};
      case (sel_s)
         SEL_ALU: begin
            rd_idx  = alu_wbck_idx;
            rd_data = alu_wbck_data;
         end
         SEL_LNG: begin
            rd_idx  = mem_idx_r[rptr_r];
            rd_data = mem_data_r[rptr_r];
         end
         default: begin
            rd_idx  = {RFIDX_W{1'b0}};
            rd_data = {XLEN{1'b0}};
         end
      endcase
      rd_wen = (sel_s != SEL_NONE) && (rd_idx != {RFIDX_W{1'b0}});
   end

   // Occupancy next-state; simultaneous push and pop cancel out.
   always_comb begin
      case ({push_s, pop_s})
         2'b10:   cnt_nxt_s = cnt_r + CNT_W'(1);
         2'b01:   cnt_nxt_s = cnt_r - CNT_W'(1);
         default: cnt_nxt_s = cnt_r;
      endcase
   end

   // Control state: pointers, valid bits, count and starvation counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_r   <= {PTR_W{1'b0}};
         rptr_r   <= {PTR_W{1'b0}};
         cnt_r    <= {CNT_W{1'b0}};
         starve_r <= {STV_W{1'b0}};
         vld_r    <= {LNG_DEPTH{1'b0}};
      end else begin
         if (push_s) begin
            vld_r[wptr_r] <= 1'b1;
            wptr_r        <= wptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            vld_r[rptr_r] <= 1'b0;
            rptr_r        <= rptr_r + PTR_W'(1);
         end
         cnt_r    <= cnt_nxt_s;
         starve_r <= starve_nxt_s;
      end
   end

   // Entry payload storage; validity is tracked separately so no reset needed.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_idx_r[wptr_r]  <= lng_wbck_idx;
         mem_data_r[wptr_r] <= lng_wbck_data;
      end
   end

endmodule

// File: tb/tb_cpu4_wbck.sv
// Self-checking bench for cpu4_wbck: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_cpu4_wbck;
   localparam int XLEN  = 32;
   localparam int RW    = 5;
   localparam int DEPTH = 2;
   localparam int MAXS  = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [RW-1:0]   idx;
      logic [XLEN-1:0] data;
   } ent_t;

   logic            clk;
   logic            rst;
   logic            alu_wbck_valid;
   logic            alu_wbck_ready;
   logic [RW-1:0]   alu_wbck_idx;
   logic [XLEN-1:0] alu_wbck_data;
   logic            lng_wbck_valid;
   logic            lng_wbck_ready;
   logic [RW-1:0]   lng_wbck_idx;
   logic [XLEN-1:0] lng_wbck_data;
   logic            rd_wen;
   logic [RW-1:0]   rd_idx;
   logic [XLEN-1:0] rd_data;
   logic [RW-1:0]   rs1_idx;
   logic [RW-1:0]   rs2_idx;
   logic            pend_hit1;
   logic            pend_hit2;
   logic [CW-1:0]   lng_pend_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   cpu4_wbck #(.XLEN(XLEN), .RFIDX_W(RW), .LNG_DEPTH(DEPTH), .MAX_STALL(MAXS)) dut (
      .clk(clk), .rst(rst),
      .alu_wbck_valid(alu_wbck_valid), .alu_wbck_ready(alu_wbck_ready),
      .alu_wbck_idx(alu_wbck_idx), .alu_wbck_data(alu_wbck_data),
      .lng_wbck_valid(lng_wbck_valid), .lng_wbck_ready(lng_wbck_ready),
      .lng_wbck_idx(lng_wbck_idx), .lng_wbck_data(lng_wbck_data),
      .rd_wen(rd_wen), .rd_idx(rd_idx), .rd_data(rd_data),
      .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
      .pend_hit1(pend_hit1), .pend_hit2(pend_hit2),
      .lng_pend_cnt(lng_pend_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      alu_wbck_valid = 1'b0;
      alu_wbck_idx   = '0;
      alu_wbck_data  = '0;
      lng_wbck_valid = 1'b0;
      lng_wbck_idx   = '0;
      lng_wbck_data  = '0;
      rs1_idx        = '0;
      rs2_idx        = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      alu_wbck_valid = 1'b1; alu_wbck_idx = 5'd5; alu_wbck_data = 32'h11;
      lng_wbck_valid = 1'b1; lng_wbck_idx = 5'd3; lng_wbck_data = 32'h22;
      rs1_idx = 5'd3; rs2_idx = 5'd3;
      for (int i = 0; i < 2; i++) begin
         next_cycle();
         #1;
         n_checks++;
         if ({alu_wbck_ready, lng_wbck_ready, rd_wen, pend_hit1, pend_hit2} !== 5'b00000)
            $display("FAIL reset_outputs: got %b want 00000",
                     {alu_wbck_ready, lng_wbck_ready, rd_wen, pend_hit1, pend_hit2});
         else n_pass++;
      end
      n_checks++;
      if (lng_pend_cnt !== 2'd0) $display("FAIL reset_cnt: got %0d want 0", lng_pend_cnt);
      else n_pass++;
      rst = 1'b0;
      lng_wbck_valid = 1'b0;
      #1;
      n_checks++;
      if ({alu_wbck_ready, rd_wen, rd_idx, rd_data} !== {1'b1, 1'b1, 5'd5, 32'h11})
         $display("FAIL reset_first_alu: got rdy=%b wen=%b idx=%0d data=%h want rdy=1 wen=1 idx=5 data=11",
                  alu_wbck_ready, rd_wen, rd_idx, rd_data);
      else n_pass++;
      next_cycle();
      idle_inputs();
   endtask

   task automatic test_long_path();
      lng_wbck_valid = 1'b1; lng_wbck_idx = 5'd7; lng_wbck_data = 32'hAB;
      rs1_idx = 5'd7;
      #1;
      n_checks++;
      if ({lng_wbck_ready, rd_wen, pend_hit1} !== 3'b100)
         $display("FAIL long_accept: got rdy/wen/hit=%b want 100", {lng_wbck_ready, rd_wen, pend_hit1});
      else n_pass++;
      next_cycle();
      lng_wbck_valid = 1'b0;
      #1;
      n_checks++;
      if ({rd_wen, rd_idx, rd_data, pend_hit1, lng_pend_cnt} !== {1'b1, 5'd7, 32'hAB, 1'b1, 2'd1})
         $display("FAIL long_write: got wen=%b idx=%0d data=%h hit=%b cnt=%0d want 1 7 ab 1 1",
                  rd_wen, rd_idx, rd_data, pend_hit1, lng_pend_cnt);
      else n_pass++;
      next_cycle();
      #1;
      n_checks++;
      if ({rd_wen, pend_hit1, lng_pend_cnt} !== {1'b0, 1'b0, 2'd0})
         $display("FAIL long_after: got wen=%b hit=%b cnt=%0d want 0 0 0", rd_wen, pend_hit1, lng_pend_cnt);
      else n_pass++;
      next_cycle();
      idle_inputs();
   endtask

   task automatic test_fifo_full();
      int cyc;
      alu_wbck_valid = 1'b1; alu_wbck_idx = 5'd1; alu_wbck_data = 32'h100;
      lng_wbck_valid = 1'b1; lng_wbck_idx = 5'd8; lng_wbck_data = 32'h800;
      #1;
      n_checks++;
      if ({alu_wbck_ready, lng_wbck_ready, rd_wen, rd_idx, rd_data} !== {1'b1, 1'b1, 1'b1, 5'd1, 32'h100})
         $display("FAIL full_c0: got ar=%b lr=%b wen=%b idx=%0d data=%h want 1 1 1 1 100",
                  alu_wbck_ready, lng_wbck_ready, rd_wen, rd_idx, rd_data);
      else n_pass++;
      next_cycle();
      lng_wbck_idx = 5'd9; lng_wbck_data = 32'h900;
      #1;
      n_checks++;
      if ({alu_wbck_ready, lng_wbck_ready} !== 2'b11)
         $display("FAIL full_c1: got ar/lr=%b want 11", {alu_wbck_ready, lng_wbck_ready});
      else n_pass++;
      next_cycle();
      lng_wbck_idx = 5'd10; lng_wbck_data = 32'hA00;
      #1;
      n_checks++;
      if ({lng_pend_cnt, lng_wbck_ready} !== {2'd2, 1'b0})
         $display("FAIL full_level: got cnt=%0d lr=%b want cnt=2 lr=0", lng_pend_cnt, lng_wbck_ready);
      else n_pass++;
      cyc = 0;
      while (alu_wbck_ready === 1'b1 && cyc < 10) begin
         next_cycle();
         #1;
         cyc++;
      end
      n_checks++;
      if (cyc !== 3) $display("FAIL full_pop_delay: got %0d cycles want 3", cyc);
      else n_pass++;
      n_checks++;
      if ({rd_wen, rd_idx, rd_data, lng_wbck_ready} !== {1'b1, 5'd8, 32'h800, 1'b0})
         $display("FAIL full_first_pop: got wen=%b idx=%0d data=%h lr=%b want 1 8 800 0",
                  rd_wen, rd_idx, rd_data, lng_wbck_ready);
      else n_pass++;
      next_cycle();
      alu_wbck_valid = 1'b0;
      #1;
      n_checks++;
      if ({lng_wbck_ready, rd_wen, rd_idx, rd_data} !== {1'b1, 1'b1, 5'd9, 32'h900})
         $display("FAIL full_third_accept: got lr=%b wen=%b idx=%0d data=%h want 1 1 9 900",
                  lng_wbck_ready, rd_wen, rd_idx, rd_data);
      else n_pass++;
      next_cycle();
      lng_wbck_valid = 1'b0;
      #1;
      n_checks++;
      if ({rd_wen, rd_idx, rd_data} !== {1'b1, 5'd10, 32'hA00})
         $display("FAIL full_third_write: got wen=%b idx=%0d data=%h want 1 10 a00", rd_wen, rd_idx, rd_data);
      else n_pass++;
      next_cycle();
      idle_inputs();
   endtask

   task automatic test_starvation();
      lng_wbck_valid = 1'b1; lng_wbck_idx = 5'd12; lng_wbck_data = 32'h55;
      next_cycle();
      lng_wbck_valid = 1'b0;
      alu_wbck_valid = 1'b1; alu_wbck_idx = 5'd3;
      for (int i = 0; i < MAXS; i++) begin
         alu_wbck_data = 32'h30 + i;
         #1;
         n_checks++;
         if ({alu_wbck_ready, rd_wen, rd_idx, rd_data} !== {1'b1, 1'b1, 5'd3, 32'h30 + i})
            $display("FAIL starve_alu%0d: got ar=%b wen=%b idx=%0d data=%h want 1 1 3 %h",
                     i, alu_wbck_ready, rd_wen, rd_idx, rd_data, 32'h30 + i);
         else n_pass++;
         next_cycle();
      end
      alu_wbck_data = 32'h40;
      #1;
      n_checks++;
      if ({alu_wbck_ready, rd_wen, rd_idx, rd_data} !== {1'b0, 1'b1, 5'd12, 32'h55})
         $display("FAIL starve_forced: got ar=%b wen=%b idx=%0d data=%h want 0 1 12 55",
                  alu_wbck_ready, rd_wen, rd_idx, rd_data);
      else n_pass++;
      next_cycle();
      #1;
      n_checks++;
      if ({alu_wbck_ready, rd_wen, rd_idx, rd_data, lng_pend_cnt} !== {1'b1, 1'b1, 5'd3, 32'h40, 2'd0})
         $display("FAIL starve_resume: got ar=%b wen=%b idx=%0d data=%h cnt=%0d want 1 1 3 40 0",
                  alu_wbck_ready, rd_wen, rd_idx, rd_data, lng_pend_cnt);
      else n_pass++;
      next_cycle();
      idle_inputs();
   endtask

   task automatic test_x0();
      alu_wbck_valid = 1'b1; alu_wbck_idx = 5'd0; alu_wbck_data = 32'hFF;
      rs1_idx = 5'd0;
      #1;
      n_checks++;
      if ({alu_wbck_ready, rd_wen} !== 2'b10)
         $display("FAIL x0_alu: got ar/wen=%b want 10", {alu_wbck_ready, rd_wen});
      else n_pass++;
      next_cycle();
      alu_wbck_valid = 1'b0;
      lng_wbck_valid = 1'b1; lng_wbck_idx = 5'd0; lng_wbck_data = 32'h33;
      #1;
      n_checks++;
      if ({lng_wbck_ready, pend_hit1} !== 2'b10)
         $display("FAIL x0_push: got lr/hit=%b want 10", {lng_wbck_ready, pend_hit1});
      else n_pass++;
      next_cycle();
      lng_wbck_valid = 1'b0;
      #1;
      n_checks++;
      if ({rd_wen, pend_hit1, lng_pend_cnt} !== {1'b0, 1'b0, 2'd1})
         $display("FAIL x0_pop: got wen=%b hit=%b cnt=%0d want 0 0 1", rd_wen, pend_hit1, lng_pend_cnt);
      else n_pass++;
      next_cycle();
      #1;
      n_checks++;
      if (lng_pend_cnt !== 2'd0) $display("FAIL x0_drained: got cnt=%0d want 0", lng_pend_cnt);
      else n_pass++;
      idle_inputs();
   endtask

   task automatic test_wrap_and_reset();
      logic [XLEN-1:0] d;
      int              wen_seen;
      for (int i = 0; i < 10; i++) begin
         d = $urandom;
         lng_wbck_valid = 1'b1; lng_wbck_idx = RW'(i + 1); lng_wbck_data = d;
         next_cycle();
         lng_wbck_valid = 1'b0;
         #1;
         n_checks++;
         if ({rd_wen, rd_idx, rd_data} !== {1'b1, RW'(i + 1), d})
            $display("FAIL wrap_%0d: got wen=%b idx=%0d data=%h want 1 %0d %h",
                     i, rd_wen, rd_idx, rd_data, i + 1, d);
         else n_pass++;
         next_cycle();
      end
      alu_wbck_valid = 1'b1; alu_wbck_idx = 5'd2; alu_wbck_data = 32'h2;
      lng_wbck_valid = 1'b1; lng_wbck_idx = 5'd20; lng_wbck_data = 32'h20;
      next_cycle();
      lng_wbck_idx = 5'd21; lng_wbck_data = 32'h21;
      next_cycle();
      idle_inputs();
      rst = 1'b1;
      #1;
      n_checks++;
      if ({lng_pend_cnt, rd_wen} !== {2'd2, 1'b0})
         $display("FAIL midrst_before: got cnt=%0d wen=%b want 2 0", lng_pend_cnt, rd_wen);
      else n_pass++;
      next_cycle();
      rst = 1'b0;
      #1;
      n_checks++;
      if (lng_pend_cnt !== 2'd0) $display("FAIL midrst_cnt: got %0d want 0", lng_pend_cnt);
      else n_pass++;
      wen_seen = 0;
      for (int i = 0; i < 4; i++) begin
         if (rd_wen !== 1'b0) wen_seen++;
         next_cycle();
         #1;
      end
      n_checks++;
      if (wen_seen !== 0) $display("FAIL midrst_no_write: got %0d writes want 0", wen_seen);
      else n_pass++;
   endtask

   task automatic test_random();
      ent_t            q[$];
      ent_t            e;
      int              starve;
      bit              alu_acc, lng_acc, pop, nonempty;
      logic            exp_ar, exp_lr, exp_wen, exp_h1, exp_h2;
      logic [RW-1:0]   exp_idx;
      logic [XLEN-1:0] exp_data;
      logic [CW-1:0]   exp_cnt;
      logic [RW+XLEN+CW+4:0] act, exp;
      idle_inputs();
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      starve = 0; alu_acc = 1'b0; lng_acc = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (alu_acc) alu_wbck_valid = 1'b0;
         if (lng_acc) lng_wbck_valid = 1'b0;
         if (!alu_wbck_valid && $urandom_range(0, 99) < 55) begin
            alu_wbck_valid = 1'b1;
            alu_wbck_idx   = ($urandom_range(0, 9) == 0) ? 5'd0 : RW'($urandom_range(1, 31));
            alu_wbck_data  = $urandom;
         end
         if (!lng_wbck_valid && $urandom_range(0, 99) < 50) begin
            lng_wbck_valid = 1'b1;
            lng_wbck_idx   = ($urandom_range(0, 9) == 0) ? 5'd0 : RW'($urandom_range(1, 31));
            lng_wbck_data  = $urandom;
         end
         rs1_idx = (q.size() > 0 && $urandom_range(0, 1) == 1) ?
                   q[$urandom_range(0, q.size() - 1)].idx : RW'($urandom_range(0, 31));
         rs2_idx = (q.size() > 0 && $urandom_range(0, 1) == 1) ?
                   q[$urandom_range(0, q.size() - 1)].idx : RW'($urandom_range(0, 31));
         #1;
         nonempty = (q.size() > 0);
         exp_cnt  = CW'(q.size());
         exp_lr   = (q.size() < DEPTH);
         alu_acc  = 1'b0; pop = 1'b0;
         if (!nonempty) begin
            exp_ar = 1'b1; alu_acc = alu_wbck_valid;
         end else if (starve < MAXS) begin
            exp_ar = 1'b1; alu_acc = alu_wbck_valid; pop = !alu_wbck_valid;
         end else begin
            exp_ar = 1'b0; pop = 1'b1;
         end
         exp_idx = '0; exp_data = '0; exp_wen = 1'b0;
         if (alu_acc) begin
            exp_wen = (alu_wbck_idx != 0); exp_idx = alu_wbck_idx; exp_data = alu_wbck_data;
         end else if (pop) begin
            exp_wen = (q[0].idx != 0); exp_idx = q[0].idx; exp_data = q[0].data;
         end
         if (!exp_wen) begin exp_idx = '0; exp_data = '0; end
         exp_h1 = 1'b0; exp_h2 = 1'b0;
         foreach (q[k]) begin
            if (q[k].idx == rs1_idx && rs1_idx != 0) exp_h1 = 1'b1;
            if (q[k].idx == rs2_idx && rs2_idx != 0) exp_h2 = 1'b1;
         end
         lng_acc = lng_wbck_valid && exp_lr;
         act = {alu_wbck_ready, lng_wbck_ready, rd_wen, rd_wen ? rd_idx : 5'd0,
                rd_wen ? rd_data : 32'd0, pend_hit1, pend_hit2, lng_pend_cnt};
         exp = {exp_ar, exp_lr, exp_wen, exp_idx, exp_data, exp_h1, exp_h2, exp_cnt};
         n_checks++;
         if (act !== exp)
            $display("FAIL random_cyc%0d: got ar=%b lr=%b wen=%b idx=%0d data=%h h1=%b h2=%b cnt=%0d want ar=%b lr=%b wen=%b idx=%0d data=%h h1=%b h2=%b cnt=%0d",
                     cyc, alu_wbck_ready, lng_wbck_ready, rd_wen, rd_idx, rd_data, pend_hit1, pend_hit2,
                     lng_pend_cnt, exp_ar, exp_lr, exp_wen, exp_idx, exp_data, exp_h1, exp_h2, exp_cnt);
         else n_pass++;
         if (pop) void'(q.pop_front());
         if (lng_acc) begin
            e.idx = lng_wbck_idx; e.data = lng_wbck_data;
            q.push_back(e);
         end
         starve = (nonempty && alu_acc) ? starve + 1 : 0;
         next_cycle();
      end
      idle_inputs();
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_long_path();
      test_fifo_full();
      test_starvation();
      test_x0();
      test_wrap_and_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
